// File: rtl/pcs_patchk_pkg.sv
// Shared definitions for the PCS loopback pattern tester: byte table, checker states
// and the helpers that build and step through the replicated pattern words.
package pcs_patchk_pkg;

    localparam int MAX_DATA_WIDTH = 128;
    localparam int TABLE_SIZE     = 16;

    localparam logic [7:0] PATTERN_BYTES [TABLE_SIZE] = '{
        8'hFF, 8'h00, 8'h55, 8'hAA, 8'hFE, 8'h07, 8'h0F, 8'hF0,
        8'h33, 8'hCC, 8'h3C, 8'hC3, 8'h01, 8'h80, 8'h1E, 8'hE1
    };

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        VERIFY,
        LOCKED
    } chk_state_t;

    // Full-width word; callers keep the low DATA_WIDTH bits, which is exact since every byte is equal.
    function automatic logic [MAX_DATA_WIDTH-1:0] pattern_word(input logic [3:0] idx);
        return {(MAX_DATA_WIDTH/8){PATTERN_BYTES[idx]}};
    endfunction

    function automatic logic [3:0] next_index(input logic [3:0] idx, input int num_patterns);
        return (int'(idx) >= num_patterns - 1) ? 4'd0 : idx + 4'd1;
    endfunction

endpackage

// File: rtl/pcs_pattern_gen.sv
// Cyclic fixed-pattern generator feeding the PCS TX SERDES interface; all outputs registered.
module pcs_pattern_gen
    import pcs_patchk_pkg::*;
#(
    parameter int                   DATA_WIDTH   = 64,
    parameter int                   HDR_WIDTH    = 2,
    parameter logic [HDR_WIDTH-1:0] EXP_HDR      = 2'b10,
    parameter int                   NUM_PATTERNS = 6
) (
    input  logic                  rx_clk,
    input  logic                  rx_rst,
    input  logic                  cfg_enable,
    output logic [DATA_WIDTH-1:0] gen_data,
    output logic [HDR_WIDTH-1:0]  gen_hdr,
    output logic                  gen_valid
);

    logic [DATA_WIDTH-1:0] pattern_tbl [TABLE_SIZE];
    logic [3:0]            gen_idx;

    for (genvar k = 0; k < TABLE_SIZE; k++) begin : g_pattern
        localparam logic [MAX_DATA_WIDTH-1:0] FULL_WORD = pattern_word(4'(k));
        assign pattern_tbl[k] = FULL_WORD[DATA_WIDTH-1:0];
    end

    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            gen_idx   <= '0;
            gen_data  <= '0;
            gen_hdr   <= '0;
            gen_valid <= 1'b0;
        end else if (!cfg_enable) begin
            gen_idx   <= '0;
            gen_data  <= '0;
            gen_hdr   <= '0;
            gen_valid <= 1'b0;
        end else begin
            gen_idx   <= next_index(gen_idx, NUM_PATTERNS);
            gen_data  <= pattern_tbl[gen_idx];
            gen_hdr   <= EXP_HDR;
            gen_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/pcs_loopback_pattern_tester.sv
// PCS line-loopback tester: pattern generator plus a self-aligning checker with lock hysteresis.
// Define PCS_PATCHK_BIT_ERR_COUNT_EN to add the saturating bit_error_count output.
module pcs_loopback_pattern_tester
    import pcs_patchk_pkg::*;
#(
    parameter int                   DATA_WIDTH   = 64,
    parameter int                   HDR_WIDTH    = 2,
    parameter logic [HDR_WIDTH-1:0] EXP_HDR      = 2'b10,
    parameter int                   NUM_PATTERNS = 6,
    parameter int                   LOCK_COUNT   = 4,
    parameter int                   UNLOCK_COUNT = 4,
    parameter int                   CNT_WIDTH    = 16
) (
    input  logic                  rx_clk,
    input  logic                  rx_rst,
    input  logic                  cfg_enable,
    input  logic                  clear_counters,
    output logic [DATA_WIDTH-1:0] gen_data,
    output logic [HDR_WIDTH-1:0]  gen_hdr,
    output logic                  gen_valid,
    input  logic [DATA_WIDTH-1:0] chk_data,
    input  logic [HDR_WIDTH-1:0]  chk_hdr,
    input  logic                  chk_valid,
    output logic                  chk_lock,
    output logic                  chk_error,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic [CNT_WIDTH-1:0]  error_count
`ifdef PCS_PATCHK_BIT_ERR_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  bit_error_count
`endif
);

    pcs_pattern_gen #(
        .DATA_WIDTH  (DATA_WIDTH),
        .HDR_WIDTH   (HDR_WIDTH),
        .EXP_HDR     (EXP_HDR),
        .NUM_PATTERNS(NUM_PATTERNS)
    ) u_gen (
        .rx_clk    (rx_clk),
        .rx_rst    (rx_rst),
        .cfg_enable(cfg_enable),
        .gen_data  (gen_data),
        .gen_hdr   (gen_hdr),
        .gen_valid (gen_valid)
    );

    chk_state_t            state;
    logic [3:0]            exp_idx;
    logic [3:0]            good_cnt;
    logic [3:0]            bad_cnt;
    logic [DATA_WIDTH-1:0] pattern_tbl [TABLE_SIZE];
    logic [DATA_WIDTH-1:0] expected_word;
    logic                  hdr_ok;
    logic                  beat_good;
    logic                  search_hit;
    logic [3:0]            search_idx;
    logic                  count_beat;

    for (genvar k = 0; k < TABLE_SIZE; k++) begin : g_pattern
        localparam logic [MAX_DATA_WIDTH-1:0] FULL_WORD = pattern_word(4'(k));
        assign pattern_tbl[k] = FULL_WORD[DATA_WIDTH-1:0];
    end

    assign expected_word = pattern_tbl[exp_idx];
    assign hdr_ok        = (chk_hdr == EXP_HDR);
    assign beat_good     = hdr_ok && (chk_data == expected_word);
    assign count_beat    = cfg_enable && chk_valid && (state == LOCKED);

    // Table entries are distinct, so at most one pattern can match a searched beat.
    always_comb begin
        search_hit = 1'b0;
        search_idx = '0;
        for (int k = 0; k < NUM_PATTERNS; k++) begin
            if (chk_data == pattern_tbl[4'(k)]) begin
                search_hit = hdr_ok;
                search_idx = 4'(k);
            end
        end
    end

    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            state     <= IDLE;
            exp_idx   <= '0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
            chk_lock  <= 1'b0;
            chk_error <= 1'b0;
        end else begin
            chk_error <= 1'b0;
            if (!cfg_enable) begin
                state    <= IDLE;
                exp_idx  <= '0;
                good_cnt <= '0;
                bad_cnt  <= '0;
                chk_lock <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= SEARCH;
                    SEARCH: begin
                        if (chk_valid && search_hit) begin
                            exp_idx  <= next_index(search_idx, NUM_PATTERNS);
                            good_cnt <= 4'd1;
                            if (LOCK_COUNT == 1) begin
                                state    <= LOCKED;
                                chk_lock <= 1'b1;
                                bad_cnt  <= '0;
                            end else begin
                                state <= VERIFY;
                            end
                        end
                    end
                    VERIFY: begin
                        if (chk_valid) begin
                            if (beat_good) begin
                                good_cnt <= good_cnt + 4'd1;
                                exp_idx  <= next_index(exp_idx, NUM_PATTERNS);
                                if (good_cnt == 4'(LOCK_COUNT - 1)) begin
                                    state    <= LOCKED;
                                    chk_lock <= 1'b1;
                                    bad_cnt  <= '0;
                                end
                            end else begin
                                state <= SEARCH;
                            end
                        end
                    end
                    LOCKED: begin
                        if (chk_valid) begin
                            exp_idx <= next_index(exp_idx, NUM_PATTERNS);
                            if (beat_good) begin
                                bad_cnt <= '0;
                            end else begin
                                chk_error <= 1'b1;
                                if (bad_cnt == 4'(UNLOCK_COUNT - 1)) begin
                                    state    <= SEARCH;
                                    chk_lock <= 1'b0;
                                    bad_cnt  <= '0;
                                end else begin
                                    bad_cnt <= bad_cnt + 4'd1;
                                end
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Counters only move on locked beats, so they naturally hold across lock loss and disable.
    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            word_count  <= '0;
            error_count <= '0;
        end else if (clear_counters) begin
            word_count  <= '0;
            error_count <= '0;
        end else if (count_beat) begin
            if (word_count != '1) word_count <= word_count + 1'b1;
            if (!beat_good && error_count != '1) error_count <= error_count + 1'b1;
        end
    end

`ifdef PCS_PATCHK_BIT_ERR_COUNT_EN
    localparam logic [CNT_WIDTH+7:0] BIT_SUM_MAX = {8'd0, {CNT_WIDTH{1'b1}}};

    logic [7:0]           beat_bit_errors;
    logic [CNT_WIDTH+7:0] bit_sum;

    assign beat_bit_errors = 8'($countones(chk_data ^ expected_word) + $countones(chk_hdr ^ EXP_HDR));
    assign bit_sum         = {8'd0, bit_error_count} + {{CNT_WIDTH{1'b0}}, beat_bit_errors};

    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            bit_error_count <= '0;
        end else if (clear_counters) begin
            bit_error_count <= '0;
        end else if (count_beat) begin
            bit_error_count <= (bit_sum > BIT_SUM_MAX) ? '1 : bit_sum[CNT_WIDTH-1:0];
        end
    end
`else
    // Without the bit-level counter only beat-level statistics are kept.
`endif

endmodule

// File: tb/tb_pcs_loopback_pattern_tester.sv
// Scoreboard bench: generator looped back to the checker through an 11-cycle delay line,
// plus a small-counter instance for saturation. Honours PCS_PATCHK_BIT_ERR_COUNT_EN.
module tb_pcs_loopback_pattern_tester;

    localparam int DW    = 64;
    localparam int SDW   = 32;
    localparam int DELAY = 11;

    logic rx_clk = 1'b0;
    always #5 rx_clk = ~rx_clk;

    logic rx_rst, cfg_enable, clear_counters;
    logic [DW-1:0] gen_data, chk_data;
    logic [1:0]    gen_hdr, chk_hdr;
    logic          gen_valid, chk_valid, chk_lock, chk_error;
    logic [15:0]   word_count, error_count;
`ifdef PCS_PATCHK_BIT_ERR_COUNT_EN
    logic [15:0]   bit_error_count;
`endif

    logic [DW-1:0] dly_data  [DELAY];
    logic [1:0]    dly_hdr   [DELAY];
    logic          dly_valid [DELAY];
    logic [DW-1:0] xor_mask, force_word;
    logic          force_en, hdr_ovr_en;

    logic            s_enable, s_clear, s_xor;
    logic [SDW-1:0]  s_gen_data;
    logic [1:0]      s_gen_hdr;
    logic            s_gen_valid, s_lock, s_error;
    logic [3:0]      s_word_count, s_error_count;
`ifdef PCS_PATCHK_BIT_ERR_COUNT_EN
    logic [3:0]      s_bit_error_count;
`endif

    int vectors    = 0;
    int miscompares = 0;

    logic [DW-1:0] exp_q[$];
    logic          exp_err_q[$];

    logic [7:0] BYTES [16] = '{8'hFF, 8'h00, 8'h55, 8'hAA, 8'hFE, 8'h07, 8'h0F, 8'hF0,
                               8'h33, 8'hCC, 8'h3C, 8'hC3, 8'h01, 8'h80, 8'h1E, 8'hE1};

    function automatic logic [DW-1:0] pat(input int k);
        return {8{BYTES[k]}};
    endfunction

    // Loopback path: delay line from the generator with optional corruption on the far end.
    always @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            for (int i = 0; i < DELAY; i++) begin
                dly_data[i]  <= '0;
                dly_hdr[i]   <= '0;
                dly_valid[i] <= 1'b0;
            end
        end else begin
            dly_data[0]  <= gen_data;
            dly_hdr[0]   <= gen_hdr;
            dly_valid[0] <= gen_valid;
            for (int i = 1; i < DELAY; i++) begin
                dly_data[i]  <= dly_data[i-1];
                dly_hdr[i]   <= dly_hdr[i-1];
                dly_valid[i] <= dly_valid[i-1];
            end
        end
    end

    assign chk_data  = force_en ? force_word : (dly_data[DELAY-1] ^ xor_mask);
    assign chk_hdr   = hdr_ovr_en ? 2'b01 : dly_hdr[DELAY-1];
    assign chk_valid = dly_valid[DELAY-1];

    pcs_loopback_pattern_tester dut (
        .rx_clk(rx_clk), .rx_rst(rx_rst), .cfg_enable(cfg_enable), .clear_counters(clear_counters),
        .gen_data(gen_data), .gen_hdr(gen_hdr), .gen_valid(gen_valid),
        .chk_data(chk_data), .chk_hdr(chk_hdr), .chk_valid(chk_valid),
        .chk_lock(chk_lock), .chk_error(chk_error),
        .word_count(word_count), .error_count(error_count)
`ifdef PCS_PATCHK_BIT_ERR_COUNT_EN
        , .bit_error_count(bit_error_count)
`endif
    );

    pcs_loopback_pattern_tester #(
        .DATA_WIDTH(SDW), .NUM_PATTERNS(16), .LOCK_COUNT(4), .UNLOCK_COUNT(15), .CNT_WIDTH(4)
    ) dut_sat (
        .rx_clk(rx_clk), .rx_rst(rx_rst), .cfg_enable(s_enable), .clear_counters(s_clear),
        .gen_data(s_gen_data), .gen_hdr(s_gen_hdr), .gen_valid(s_gen_valid),
        .chk_data(s_gen_data ^ {{(SDW-1){1'b0}}, s_xor}), .chk_hdr(s_gen_hdr), .chk_valid(s_gen_valid),
        .chk_lock(s_lock), .chk_error(s_error),
        .word_count(s_word_count), .error_count(s_error_count)
`ifdef PCS_PATCHK_BIT_ERR_COUNT_EN
        , .bit_error_count(s_bit_error_count)
`endif
    );

    task automatic wait_lock(input int bound, output int cycles);
        cycles = 0;
        while (chk_lock !== 1'b1 && cycles < bound) begin
            @(negedge rx_clk);
            cycles++;
        end
    endtask

    task automatic bad_beats(input int n);
        force_word = 64'h0123456789ABCDEF;
        force_en   = 1'b1;
        repeat (n) @(negedge rx_clk);
        force_en = 1'b0;
    endtask

    task automatic test_reset();
        rx_rst = 1'b1;
        repeat (2) @(negedge rx_clk);
        vectors++;
        if ({gen_valid, gen_hdr, gen_data} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_gen: got %0h expected 0", {gen_valid, gen_hdr, gen_data});
        end
        vectors++;
        if ({chk_lock, chk_error, word_count, error_count} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_chk: got %0h expected 0", {chk_lock, chk_error, word_count, error_count});
        end
        vectors++;
        if ({s_lock, s_error, s_word_count, s_error_count} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_sat: got %0h expected 0", {s_lock, s_error, s_word_count, s_error_count});
        end
        rx_rst = 1'b0;
        @(negedge rx_clk);
    endtask

    task automatic test_generator();
        logic [DW-1:0] e;
        cfg_enable = 1'b1;
        for (int i = 0; i < 9; i++) exp_q.push_back(pat(i % 6));
        for (int i = 0; i < 9; i++) begin
            @(negedge rx_clk);
            e = exp_q.pop_front();
            vectors++;
            if ({gen_valid, gen_hdr, gen_data} !== {1'b1, 2'b10, e}) begin
                miscompares++;
                $display("[TB] FAIL gen_word%0d: got %0h expected %0h", i, {gen_valid, gen_hdr, gen_data}, {1'b1, 2'b10, e});
            end
        end
        cfg_enable = 1'b0;
        @(negedge rx_clk);
        vectors++;
        if ({gen_valid, gen_hdr, gen_data} !== '0) begin
            miscompares++;
            $display("[TB] FAIL gen_disable: got %0h expected 0", {gen_valid, gen_hdr, gen_data});
        end
    endtask

    task automatic test_lock_through_delay();
        int cyc;
        rx_rst = 1'b1;
        @(negedge rx_clk);
        rx_rst = 1'b0;
        @(negedge rx_clk);
        cfg_enable = 1'b1;
        wait_lock(40, cyc);
        vectors++;
        if (chk_lock !== 1'b1 || cyc > 17) begin
            miscompares++;
            $display("[TB] FAIL lock_latency: got lock=%0b after %0d cycles expected lock within 17", chk_lock, cyc);
        end
        repeat (1000) @(negedge rx_clk);
        vectors++;
        if (word_count !== 16'd1000 || error_count !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL clean_run: got words=%0d errors=%0d expected 1000/0", word_count, error_count);
        end
    endtask

    task automatic test_single_corruption();
        logic e;
        for (int i = 0; i < 4; i++) begin
            xor_mask = (i == 1) ? 64'h1 : 64'h0;
            exp_err_q.push_back(i == 1);
            @(negedge rx_clk);
            e = exp_err_q.pop_front();
            vectors++;
            if (chk_error !== e) begin
                miscompares++;
                $display("[TB] FAIL corrupt_pulse%0d: got %0b expected %0b", i, chk_error, e);
            end
        end
        xor_mask = '0;
        vectors++;
        if (error_count !== 16'd1 || chk_lock !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL corrupt_count: got errors=%0d lock=%0b expected 1/1", error_count, chk_lock);
        end
`ifdef PCS_PATCHK_BIT_ERR_COUNT_EN
        vectors++;
        if (bit_error_count !== 16'd1) begin
            miscompares++;
            $display("[TB] FAIL corrupt_bits: got %0d expected 1", bit_error_count);
        end
`endif
    endtask

    task automatic test_loss_and_reacquire();
        logic e;
        clear_counters = 1'b1;
        @(negedge rx_clk);
        clear_counters = 1'b0;
        vectors++;
        if (word_count !== 16'd0 || error_count !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL clear: got words=%0d errors=%0d expected 0/0", word_count, error_count);
        end
        force_word = 64'h0123456789ABCDEF;
        for (int i = 0; i < 4; i++) begin
            force_en = 1'b1;
            exp_err_q.push_back(1'b1);
            @(negedge rx_clk);
            e = exp_err_q.pop_front();
            vectors++;
            if (chk_error !== e || chk_lock !== (i < 3)) begin
                miscompares++;
                $display("[TB] FAIL loss_beat%0d: got err=%0b lock=%0b expected %0b/%0b", i, chk_error, chk_lock, e, i < 3);
            end
        end
        force_en = 1'b0;
        vectors++;
        if (error_count !== 16'd4) begin
            miscompares++;
            $display("[TB] FAIL loss_errors: got %0d expected 4", error_count);
        end
        for (int i = 0; i < 4; i++) begin
            exp_err_q.push_back(1'b0);
            @(negedge rx_clk);
            e = exp_err_q.pop_front();
            vectors++;
            if (chk_error !== e || chk_lock !== (i == 3)) begin
                miscompares++;
                $display("[TB] FAIL reacquire%0d: got err=%0b lock=%0b expected %0b/%0b", i, chk_error, chk_lock, e, i == 3);
            end
        end
        vectors++;
        if (error_count !== 16'd4) begin
            miscompares++;
            $display("[TB] FAIL hold_errors: got %0d expected 4", error_count);
        end
    endtask

    task automatic test_header_mismatch();
        int cyc;
        logic e;
        bad_beats(4);
        hdr_ovr_en = 1'b1;
        repeat (10) @(negedge rx_clk);
        vectors++;
        if (chk_lock !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL hdr_search: got lock=%0b expected 0", chk_lock);
        end
        hdr_ovr_en = 1'b0;
        wait_lock(8, cyc);
        vectors++;
        if (chk_lock !== 1'b1 || cyc != 4) begin
            miscompares++;
            $display("[TB] FAIL hdr_relock: got lock=%0b after %0d expected 1 after 4", chk_lock, cyc);
        end
        clear_counters = 1'b1;
        @(negedge rx_clk);
        clear_counters = 1'b0;
        hdr_ovr_en = 1'b1;
        exp_err_q.push_back(1'b1);
        @(negedge rx_clk);
        hdr_ovr_en = 1'b0;
        e = exp_err_q.pop_front();
        vectors++;
        if (chk_error !== e || error_count !== 16'd1 || chk_lock !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL hdr_locked: got err=%0b count=%0d lock=%0b expected 1/1/1", chk_error, error_count, chk_lock);
        end
`ifdef PCS_PATCHK_BIT_ERR_COUNT_EN
        vectors++;
        if (bit_error_count !== 16'd2) begin
            miscompares++;
            $display("[TB] FAIL hdr_bits: got %0d expected 2", bit_error_count);
        end
`endif
    endtask

    task automatic test_reset_mid_lock();
        int cyc;
        #2 rx_rst = 1'b1;
        #1;
        vectors++;
        if ({gen_valid, gen_hdr, gen_data, chk_lock, chk_error, word_count, error_count} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid: got lock=%0b words=%0d errors=%0d gen_valid=%0b expected all 0",
                     chk_lock, word_count, error_count, gen_valid);
        end
        @(negedge rx_clk);
        rx_rst = 1'b0;
        wait_lock(40, cyc);
        vectors++;
        if (chk_lock !== 1'b1 || error_count !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_relock: got lock=%0b errors=%0d expected 1/0", chk_lock, error_count);
        end
    endtask

    task automatic test_saturation_and_clear();
        int cyc;
        logic e;
        s_enable = 1'b1;
        cyc = 0;
        while (s_lock !== 1'b1 && cyc < 30) begin
            @(negedge rx_clk);
            cyc++;
        end
        repeat (30) @(negedge rx_clk);
        vectors++;
        if (s_lock !== 1'b1 || s_word_count !== 4'd15 || s_error_count !== 4'd0) begin
            miscompares++;
            $display("[TB] FAIL sat_words: got lock=%0b words=%0d errors=%0d expected 1/15/0", s_lock, s_word_count, s_error_count);
        end
        s_clear = 1'b1;
        @(negedge rx_clk);
        s_clear = 1'b0;
        for (int i = 0; i < 20; i++) begin
            s_xor = 1'b1;
            exp_err_q.push_back(i < 15);
            @(negedge rx_clk);
            e = exp_err_q.pop_front();
            vectors++;
            if (s_error !== e || s_lock !== (i < 14)) begin
                miscompares++;
                $display("[TB] FAIL sat_beat%0d: got err=%0b lock=%0b expected %0b/%0b", i, s_error, s_lock, e, i < 14);
            end
        end
        s_xor = 1'b0;
        vectors++;
        if (s_error_count !== 4'd15) begin
            miscompares++;
            $display("[TB] FAIL sat_errors: got %0d expected 15", s_error_count);
        end
        cyc = 0;
        while (s_lock !== 1'b1 && cyc < 30) begin
            @(negedge rx_clk);
            cyc++;
        end
        s_clear = 1'b1;
        s_xor   = 1'b1;
        exp_err_q.push_back(1'b1);
        @(negedge rx_clk);
        s_clear = 1'b0;
        s_xor   = 1'b0;
        e = exp_err_q.pop_front();
        vectors++;
        if (s_error !== e || s_error_count !== 4'd0 || s_word_count !== 4'd0) begin
            miscompares++;
            $display("[TB] FAIL clear_wins: got err=%0b errors=%0d words=%0d expected 1/0/0", s_error, s_error_count, s_word_count);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rx_rst         = 1'b1;
        cfg_enable     = 1'b0;
        clear_counters = 1'b0;
        xor_mask       = '0;
        force_word     = '0;
        force_en       = 1'b0;
        hdr_ovr_en     = 1'b0;
        s_enable       = 1'b0;
        s_clear        = 1'b0;
        s_xor          = 1'b0;
        @(negedge rx_clk);
        test_reset();
        test_generator();
        test_lock_through_delay();
        test_single_corruption();
        test_loss_and_reacquire();
        test_header_mismatch();
        test_reset_mid_lock();
        test_saturation_and_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
